// File: rtl/lsu_wb_retry_queue_pkg.sv
// Shared types for the LSU low-priority writeback retry queue.
// An entry is one buffered writeback: the uop tag fields, the data and the predicated flag.
package lsu_wb_pkg;

    localparam int ROB_IDX_W = 7;
    localparam int PREG_W    = 7;
    localparam int DATA_W    = 64;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pdst;
        logic                 is_amo;
        logic                 uses_stq;
        logic [1:0]           dst_rtype;
    } wb_uop_t;

    typedef struct packed {
        wb_uop_t           uop;
        logic [DATA_W-1:0] data;
        logic              predicated;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // Builds an entry from the field-level port values.
    function automatic wb_entry_t wb_entry_pack(
        input logic [ROB_IDX_W-1:0] rob_idx,
        input logic [PREG_W-1:0]    pdst,
        input logic                 is_amo,
        input logic                 uses_stq,
        input logic [1:0]           dst_rtype,
        input logic [DATA_W-1:0]    data,
        input logic                 predicated
    );
        wb_entry_t e;
        e.uop.rob_idx   = rob_idx;
        e.uop.pdst      = pdst;
        e.uop.is_amo    = is_amo;
        e.uop.uses_stq  = uses_stq;
        e.uop.dst_rtype = dst_rtype;
        e.data          = data;
        e.predicated    = predicated;
        return e;
    endfunction

endpackage

// File: rtl/lsu_wb_retry_queue_if.sv
// Enqueue/dequeue/flush bundle of the writeback retry queue.
// slave is the queue's view; master is the producer/arbiter-side view.
interface lsu_wb_retry_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    import lsu_wb_pkg::*;

    logic                 io_flush;

    logic                 io_enq_valid;
    logic                 io_enq_ready;
    logic [ROB_IDX_W-1:0] io_enq_bits_uop_rob_idx;
    logic [PREG_W-1:0]    io_enq_bits_uop_pdst;
    logic                 io_enq_bits_uop_is_amo;
    logic                 io_enq_bits_uop_uses_stq;
    logic [1:0]           io_enq_bits_uop_dst_rtype;
    logic [DATA_W-1:0]    io_enq_bits_data;
    logic                 io_enq_bits_predicated;

    logic                 io_deq_valid;
    logic                 io_deq_ready;
    logic [ROB_IDX_W-1:0] io_deq_bits_uop_rob_idx;
    logic [PREG_W-1:0]    io_deq_bits_uop_pdst;
    logic                 io_deq_bits_uop_is_amo;
    logic                 io_deq_bits_uop_uses_stq;
    logic [1:0]           io_deq_bits_uop_dst_rtype;
    logic [DATA_W-1:0]    io_deq_bits_data;
    logic                 io_deq_bits_predicated;

    logic [CNT_W-1:0]     io_count;

    modport slave (
        input  io_flush,
        input  io_enq_valid, io_enq_bits_uop_rob_idx, io_enq_bits_uop_pdst,
               io_enq_bits_uop_is_amo, io_enq_bits_uop_uses_stq,
               io_enq_bits_uop_dst_rtype, io_enq_bits_data, io_enq_bits_predicated,
        output io_enq_ready,
        output io_deq_valid, io_deq_bits_uop_rob_idx, io_deq_bits_uop_pdst,
               io_deq_bits_uop_is_amo, io_deq_bits_uop_uses_stq,
               io_deq_bits_uop_dst_rtype, io_deq_bits_data, io_deq_bits_predicated,
        input  io_deq_ready,
        output io_count
    );

    modport master (
        output io_flush,
        output io_enq_valid, io_enq_bits_uop_rob_idx, io_enq_bits_uop_pdst,
               io_enq_bits_uop_is_amo, io_enq_bits_uop_uses_stq,
               io_enq_bits_uop_dst_rtype, io_enq_bits_data, io_enq_bits_predicated,
        input  io_enq_ready,
        input  io_deq_valid, io_deq_bits_uop_rob_idx, io_deq_bits_uop_pdst,
               io_deq_bits_uop_is_amo, io_deq_bits_uop_uses_stq,
               io_deq_bits_uop_dst_rtype, io_deq_bits_data, io_deq_bits_predicated,
        output io_deq_ready,
        input  io_count
    );

endinterface

// File: rtl/lsu_wb_retry_queue.sv
// In-order retry queue feeding the low-priority writeback arbiter port.
// Head entry drives deq directly from storage; ready/valid depend on registered count only.
module lsu_wb_retry_queue
    import lsu_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    lsu_wb_retry_queue_if.slave  io
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_enq_ready;
    logic             w_deq_valid;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic [CNT_W-1:0] w_count_nxt;
    wb_entry_t        w_enq_entry;
    wb_entry_t        w_head_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign w_enq_ready = (r_count != CNT_W'(DEPTH));
    assign w_deq_valid = (r_count != {CNT_W{1'b0}});
    // Flush suppresses both handshakes as far as queue state is concerned.
    assign w_enq_fire  = io.io_enq_valid && w_enq_ready && !io.io_flush;
    assign w_deq_fire  = io.io_deq_ready && w_deq_valid && !io.io_flush;

    assign w_enq_entry = wb_entry_pack(io.io_enq_bits_uop_rob_idx, io.io_enq_bits_uop_pdst,
                                       io.io_enq_bits_uop_is_amo, io.io_enq_bits_uop_uses_stq,
                                       io.io_enq_bits_uop_dst_rtype, io.io_enq_bits_data,
                                       io.io_enq_bits_predicated);
    assign w_head_entry = r_mem[r_head];

    // Occupancy next-state from the two handshakes.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq_fire, w_deq_fire})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            2'b11:   w_count_nxt = r_count;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and count registers; flush returns them to the empty origin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else if (io.io_flush) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_enq_fire) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_deq_fire) begin
                r_head <= ptr_inc(r_head);
            end
            r_count <= w_count_nxt;
        end
    end

    // Entry storage; contents survive flush, only reset clears them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_enq_fire) begin
            r_mem[r_tail] <= w_enq_entry;
        end
    end

    assign io.io_enq_ready              = w_enq_ready;
    assign io.io_deq_valid              = w_deq_valid;
    assign io.io_count                  = r_count;
    assign io.io_deq_bits_uop_rob_idx   = w_head_entry.uop.rob_idx;
    assign io.io_deq_bits_uop_pdst      = w_head_entry.uop.pdst;
    assign io.io_deq_bits_uop_is_amo    = w_head_entry.uop.is_amo;
    assign io.io_deq_bits_uop_uses_stq  = w_head_entry.uop.uses_stq;
    assign io.io_deq_bits_uop_dst_rtype = w_head_entry.uop.dst_rtype;
    assign io.io_deq_bits_data          = w_head_entry.data;
    assign io.io_deq_bits_predicated    = w_head_entry.predicated;

endmodule

// File: tb/tb_lsu_wb_retry_queue.sv
// Directed bench for lsu_wb_retry_queue with an in-order expected-entry queue.
module tb_lsu_wb_retry_queue;
    import lsu_wb_pkg::*;

    localparam int DEPTH = 4;

    logic clock;
    logic reset_n;

    lsu_wb_retry_queue_if #(.DEPTH(DEPTH)) io ();

    lsu_wb_retry_queue #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (io)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int        n_checks = 0;
    int        n_err    = 0;
    int        m_count  = 0;
    wb_entry_t sb [$];
    wb_entry_t cur_e;

    task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_entry_t mk(input int rob, input int pdst, input logic [63:0] data, input logic pred);
        logic [6:0] r;
        r = 7'(rob);
        return wb_entry_pack(r, 7'(pdst), r[0], r[1], r[3:2], data, pred);
    endfunction

    function automatic wb_entry_t head_obs();
        return wb_entry_pack(io.io_deq_bits_uop_rob_idx, io.io_deq_bits_uop_pdst,
                             io.io_deq_bits_uop_is_amo, io.io_deq_bits_uop_uses_stq,
                             io.io_deq_bits_uop_dst_rtype, io.io_deq_bits_data,
                             io.io_deq_bits_predicated);
    endfunction

    task automatic drive_enq(input logic v, input wb_entry_t e);
        cur_e                        = e;
        io.io_enq_valid              = v;
        io.io_enq_bits_uop_rob_idx   = e.uop.rob_idx;
        io.io_enq_bits_uop_pdst      = e.uop.pdst;
        io.io_enq_bits_uop_is_amo    = e.uop.is_amo;
        io.io_enq_bits_uop_uses_stq  = e.uop.uses_stq;
        io.io_enq_bits_uop_dst_rtype = e.uop.dst_rtype;
        io.io_enq_bits_data          = e.data;
        io.io_enq_bits_predicated    = e.predicated;
    endtask

    // Check outputs against the model, clock once, then update the model.
    task automatic cycle();
        logic exp_ready;
        logic enq_fire;
        logic deq_fire;
        exp_ready = (m_count != DEPTH);
        chk("enq_ready", io.io_enq_ready, exp_ready);
        chk("deq_valid", io.io_deq_valid, (m_count != 0));
        chk("count", io.io_count, m_count);
        if (m_count != 0) chk("deq_bits", head_obs(), sb[0]);
        enq_fire = io.io_enq_valid && exp_ready;
        deq_fire = io.io_deq_ready && (m_count != 0);
        @(posedge clock);
        #1;
        if (io.io_flush) begin
            sb.delete();
        end else begin
            if (deq_fire) void'(sb.pop_front());
            if (enq_fire) sb.push_back(cur_e);
        end
        m_count = sb.size();
    endtask

    task automatic drain();
        drive_enq(1'b0, '0);
        io.io_deq_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH + 2 && m_count != 0; k++) cycle();
        chk("drain_empty", io.io_count, 0);
    endtask

    initial begin
        reset_n         = 1'b0;
        io.io_flush     = 1'b0;
        io.io_deq_ready = 1'b1;
        drive_enq(1'b0, '0);
        #12;
        chk("rst_deq_valid", io.io_deq_valid, 1'b0);
        chk("rst_enq_ready", io.io_enq_ready, 1'b1);
        chk("rst_count", io.io_count, 0);
        chk("rst_deq_bits", head_obs(), '0);
        reset_n = 1'b1;

        // Single entry round trip.
        drive_enq(1'b1, mk(5, 9, 64'hDEAD_BEEF, 1'b0));
        cycle();
        drive_enq(1'b0, '0);
        chk("t1_count1", io.io_count, 1);
        chk("t1_valid", io.io_deq_valid, 1'b1);
        chk("t1_rob", io.io_deq_bits_uop_rob_idx, 5);
        chk("t1_pdst", io.io_deq_bits_uop_pdst, 9);
        chk("t1_data", io.io_deq_bits_data, 64'hDEAD_BEEF);
        cycle();
        chk("t1_count0", io.io_count, 0);

        // Fill with arbiter stalled; the fifth entry is held off.
        io.io_deq_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive_enq(1'b1, mk(i, 10 + i, 64'h1000 + 64'(i), 1'(i % 2)));
            cycle();
        end
        chk("t2_full_count", io.io_count, 4);
        chk("t2_full_ready", io.io_enq_ready, 1'b0);
        chk("t2_head_is_1", io.io_deq_bits_uop_rob_idx, 1);
        // Full with both handshakes offered: only the dequeue happens.
        io.io_deq_ready = 1'b1;
        cycle();
        chk("t3_count3", io.io_count, 3);
        chk("t3_head_is_2", io.io_deq_bits_uop_rob_idx, 2);
        cycle();
        chk("t3_count_hold", io.io_count, 3);
        drain();

        // Streaming through a half-full queue; pointers wrap several times.
        io.io_deq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_enq(1'b1, mk(40 + i, 50 + i, {$urandom, $urandom}, 1'b0));
            cycle();
        end
        io.io_deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_enq(1'b1, mk(60 + i, 70 + i, {$urandom, $urandom}, 1'(i % 2)));
            cycle();
            chk("t4_count_const", io.io_count, 2);
        end
        drain();

        // Flush with an enqueue offered in the same cycle.
        io.io_deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(1'b1, mk(80 + i, 1, 64'h80 + 64'(i), 1'b0));
            cycle();
        end
        chk("t5_count3", io.io_count, 3);
        io.io_flush = 1'b1;
        drive_enq(1'b1, mk(119, 119, 64'h7777, 1'b1));
        cycle();
        io.io_flush = 1'b0;
        chk("t5_flush_count", io.io_count, 0);
        chk("t5_flush_valid", io.io_deq_valid, 1'b0);
        drive_enq(1'b1, mk(90, 2, 64'h9090, 1'b0));
        cycle();
        chk("t5_post_rob", io.io_deq_bits_uop_rob_idx, 90);
        drain();

        // Asynchronous reset between clock edges.
        io.io_deq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_enq(1'b1, mk(100 + i, 3, 64'hA0 + 64'(i), 1'b0));
            cycle();
        end
        drive_enq(1'b0, '0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", io.io_deq_valid, 1'b0);
        chk("t6_rst_count", io.io_count, 0);
        chk("t6_rst_ready", io.io_enq_ready, 1'b1);
        sb.delete();
        m_count = 0;
        #2;
        reset_n = 1'b1;
        #4;
        drive_enq(1'b1, mk(51, 4, 64'h0123_4567_89AB_CDEF, 1'b1));
        cycle();
        drive_enq(1'b1, mk(52, 5, 64'h55, 1'b0));
        cycle();
        chk("t6_first_rob", io.io_deq_bits_uop_rob_idx, 51);
        chk("t6_first_pred", io.io_deq_bits_predicated, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
